sample_rate_bridge: RTL and testbench
=====================================

SAMPLE_RATE_BRIDGE -- requirements
Module: sample_rate_bridge

Interface
REQ-001 Parameter DATA_W, default 12: sample width in bits.
REQ-002 Parameter DEPTH, default 4: buffer depth in samples; power of two, minimum 2.
REQ-003 Parameter CNT_W, default 8: underrun counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  slow-rate sample strobe, one cycle per sample.
REQ-007 in_data  input  DATA_W  sample, qualified by in_valid.
REQ-008 out_en  input  1  fast-rate output tick (clock enable).
REQ-009 mode  input  1  underrun fill: 0 = hold last sample, 1 = zero-stuff.
REQ-010 clr_flags  input  1  synchronous clear of overflow and underrun_cnt.
REQ-011 out_data  output  DATA_W  registered output sample.
REQ-012 out_valid  output  1  one-cycle pulse marking a new out_data.
REQ-013 level  output  $clog2(DEPTH)+1  samples currently buffered.
REQ-014 full / empty  output  1 each  level==DEPTH / level==0.
REQ-015 overflow  output  1  sticky: a sample was dropped.
REQ-016 underrun_cnt  output  CNT_W  saturating count of fill ticks.

Function
REQ-017 Buffer SHALL be a DEPTH-entry circular FIFO with wrapping read/write pointers; level = writes minus reads.
REQ-018 Push: in_valid=1 and (not full, or out_en=1 in the same cycle) SHALL store in_data at the write pointer.
REQ-019 Drop: in_valid=1, full, out_en=0 SHALL discard the sample, leave the FIFO unchanged, and set overflow.
REQ-020 Pop: out_en=1 and not empty SHALL, at that edge, load out_data with the head sample, advance the read pointer, and latch it as last_sample.
REQ-021 Underrun: out_en=1 and empty SHALL load out_data with last_sample (mode=0) or zero (mode=1), leave last_sample unchanged, and increment underrun_cnt, saturating at 2^CNT_W-1.
REQ-022 in_valid with out_en while empty SHALL NOT bypass: the sample is stored, the output follows REQ-021, and level becomes 1.
REQ-023 in_valid with out_en while full SHALL pop the head and push the new sample; level stays DEPTH and overflow is not set.
REQ-024 out_valid SHALL be 1 on the cycle after every edge with out_en=1, otherwise 0; out_data SHALL hold between ticks.
REQ-025 mode SHALL be sampled on the out_en edge; a change never alters buffer contents.
REQ-026 clr_flags SHALL clear overflow and underrun_cnt at the edge; a set or increment event in the same cycle SHALL take priority.
REQ-027 Latency from a push to an output SHALL be one out_en tick if the buffer was empty before the push, out_data updating at that tick's edge.

Reset
REQ-028 rst_n=0 SHALL immediately reset to zero: pointers, level, out_data, last_sample, out_valid, overflow, and underrun_cnt; empty=1, full=0.
REQ-029 Reset mid-operation SHALL discard all buffered samples; the first out_en after release SHALL follow REQ-021 with last_sample=0.
REQ-030 Buffer RAM contents SHALL NOT need reset.

Verification
REQ-031 Stream: in_valid every 5 cycles with data 10,1,0,5,54; out_en every cycle; mode=0 -> out_data sequence 10,10,10,10,10,1,... with no overflow and underrun_cnt counting fill ticks.
REQ-032 Zero-stuff: same stimulus, mode=1 -> each sample appears once, followed by 0 on every fill tick.
REQ-033 Overflow: 6 pushes with DEPTH=4 and no out_en -> level=4, full=1, overflow=1; 4 ticks then yield the first 4 samples in order, then 2 fill ticks.
REQ-034 Simultaneous: full buffer, in_valid and out_en together -> head emitted, new sample buffered, level=4, overflow=0; empty buffer, both together -> fill output, level=1.
REQ-035 Saturation/clear: 300 ticks while empty with CNT_W=8 -> underrun_cnt=255; clr_flags pulse -> 0 and overflow=0.
REQ-036 Reset: assert rst_n=0 with 3 samples buffered -> all outputs 0 and empty=1 asynchronously; next out_en gives out_data=0.

Source files
------------

// File: rtl/sample_rate_bridge.sv
// Slow-to-fast sample rate bridge: a small circular FIFO drained on each
// out_en tick, with hold-last or zero-stuff fill on underrun.
module sample_rate_bridge #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_en,
  input  logic                     mode,
  input  logic                     clr_flags,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    FILL_HOLD = 2'b00,
    FILL_ZERO = 2'b01
  } fill_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] last_sample;

  logic  do_push;
  logic  do_pop;
  logic  do_drop;
  logic  do_fill;
  fill_e fill_sel;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);

  // A pop on the same edge frees a slot, so a full buffer can still accept.
  assign do_push = in_valid && (!full || out_en);
  assign do_pop  = out_en && !empty;
  assign do_drop = in_valid && full && !out_en;
  assign do_fill = out_en && empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fill_sel = FILL_HOLD;
    if (mode) fill_sel = FILL_ZERO;
  end

  // NOTE: the sample storage has no reset; stale entries are never read because
  // level gates every pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Output register: head sample on a pop, fill value on an underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      last_sample <= '0;
    end else begin
      out_valid <= out_en;
      if (do_pop) begin
        out_data    <= mem[rd_ptr];
        last_sample <= mem[rd_ptr];
      end else if (do_fill) begin
        out_data <= (fill_sel == FILL_ZERO) ? '0 : last_sample;
      end
    end
  end

  // Set/increment events win over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (do_drop)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (do_fill) begin
        if (underrun_cnt != CNT_MAX) underrun_cnt <= underrun_cnt + CNT_W'(1);
      end else if (clr_flags) begin
        underrun_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sample_rate_bridge.sv
// Directed self-checking bench for sample_rate_bridge (DATA_W=12, DEPTH=4, CNT_W=8).
module tb_sample_rate_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_en;
  logic        mode;
  logic        clr_flags;
  logic [11:0] out_data;
  logic        out_valid;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  underrun_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  sample_rate_bridge #(.DATA_W(12), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_en(out_en), .mode(mode), .clr_flags(clr_flags),
    .out_data(out_data), .out_valid(out_valid), .level(level),
    .full(full), .empty(empty), .overflow(overflow), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    in_valid  = 1'b0;
    out_en    = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  int          vals [5] = '{10, 1, 0, 5, 54};
  logic [11:0] exp_out;
  logic [11:0] last;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_en = 1'b0;
    mode = 1'b0; clr_flags = 1'b0;
    #3;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underrun", underrun_cnt, 0);
    #10 rst_n = 1'b1;
    tick();

    // Stream, hold-last fill.
    mode = 1'b0;
    last = '0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = (c == 0);
        in_data  = 12'(vals[k]);
        out_en   = 1'b1;
        tick();
        if (c == 1) begin
          exp_out = 12'(vals[k]);
          last    = exp_out;
        end else begin
          exp_out = last;
        end
        check("hold_out_data", out_data, exp_out);
        check("hold_out_valid", out_valid, 1);
        if (c == 0) check("hold_level_push", level, 1);
        if (c == 1) check("hold_level_pop", level, 0);
      end
    end
    check("hold_underrun", underrun_cnt, 20);
    check("hold_overflow", overflow, 0);
    do_clr();
    check("clr_underrun", underrun_cnt, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_out_hold", out_data, 54);

    // Stream, zero-stuff fill.
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = (c == 0);
        in_data  = 12'(vals[k]);
        out_en   = 1'b1;
        tick();
        exp_out = (c == 1) ? 12'(vals[k]) : 12'd0;
        check("zero_out_data", out_data, exp_out);
      end
    end
    check("zero_underrun", underrun_cnt, 20);
    do_clr();

    // Overflow: six pushes with no drain; clear on the last drop loses to the set.
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      in_data   = 12'h101 + 12'(i);
      out_en    = 1'b0;
      clr_flags = (i == 5);
      tick();
      if (i == 3) begin
        check("ovf_level4", level, 4);
        check("ovf_full", full, 1);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 4) check("ovf_set", overflow, 1);
    end
    clr_flags = 1'b0;
    check("ovf_clr_loses", overflow, 1);
    check("ovf_level_final", level, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_en = 1'b1;
      tick();
      check("ovf_drain_data", out_data, 12'h101 + 12'(i));
      check("ovf_drain_level", level, 3 - i);
    end
    check("ovf_empty", empty, 1);
    tick();
    check("ovf_fill1", out_data, 12'h104);
    tick();
    check("ovf_fill2", out_data, 12'h104);
    check("ovf_underrun2", underrun_cnt, 2);
    mode = 1'b1;
    tick();
    check("ovf_fill_zero", out_data, 0);
    do_clr();
    check("clr_overflow", overflow, 0);
    check("clr_underrun2", underrun_cnt, 0);

    // Simultaneous push/pop while full, then while empty.
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h201 + 12'(i);
      out_en   = 1'b0;
      tick();
    end
    in_data = 12'h205;
    out_en  = 1'b1;
    tick();
    check("sim_full_out", out_data, 12'h201);
    check("sim_full_level", level, 4);
    check("sim_full_ovf", overflow, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sim_drain", out_data, 12'h202 + 12'(i));
    end
    in_valid = 1'b1;
    in_data  = 12'h2AA;
    tick();
    check("sim_empty_out", out_data, 12'h205);
    check("sim_empty_level", level, 1);
    check("sim_empty_underrun", underrun_cnt, 1);
    in_valid = 1'b0;
    tick();
    check("sim_next_out", out_data, 12'h2AA);
    out_en = 1'b0;
    tick();
    check("sim_hold_valid", out_valid, 0);
    check("sim_hold_data", out_data, 12'h2AA);
    do_clr();

    // Saturation, then clear racing an increment, then plain clear.
    out_en = 1'b1;
    repeat (300) tick();
    check("sat_cnt", underrun_cnt, 255);
    clr_flags = 1'b1;
    tick();
    check("sat_clr_loses", underrun_cnt, 255);
    out_en = 1'b0;
    tick();
    clr_flags = 1'b0;
    check("sat_clr", underrun_cnt, 0);
    check("sat_clr_ovf", overflow, 0);

    // Asynchronous reset with three samples buffered.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h301 + 12'(i);
      tick();
    end
    in_valid = 1'b0;
    out_en   = 1'b1;
    tick();
    check("pre_rst_out", out_data, 12'h301);
    check("pre_rst_level", level, 3);
    check("pre_rst_ovf", overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_data", out_data, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_overflow", overflow, 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_out", out_data, 0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_level", level, 0);
    check("post_rst_underrun", underrun_cnt, 1);
    out_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
